// File: rtl/tlu_handshake_pkg.sv
// Shared constants for the TLU handshake controller: mode codes, FSM state encoding
// and small mode-decoding helpers.
package tlu_handshake_pkg;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_SIMPLE = 2'b01;
    localparam logic [1:0] MODE_DATA   = 2'b10;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_SEND_CMD      = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG_LOW = 3'd2;
    localparam logic [2:0] ST_SHIFT         = 3'd3;
    localparam logic [2:0] ST_PRESENT       = 3'd4;
    localparam logic [2:0] ST_WAIT_CMD      = 3'd5;

    // Mode 11 is undefined on the TLU side and behaves exactly like "no handshake".
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_NONE : m;
    endfunction

    function automatic logic is_handshake(input logic [1:0] m);
        return (m == MODE_SIMPLE) || (m == MODE_DATA);
    endfunction

endpackage

// File: rtl/tlu_data_shifter.sv
// Generates TLU_CLOCK for one trigger-number readout and shifts the serial
// trigger number in LSB first; start launches a run, done flags its last cycle.
module tlu_data_shifter #(
    parameter int DATA_WIDTH = 15,
    parameter int CCK_HALF   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  data_in,
    output logic                  tlu_clock,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int PH_W  = (2 * CCK_HALF > 1) ? $clog2(2 * CCK_HALF) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(CCK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CCK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    logic             active;
    logic [PH_W-1:0]  phase;
    logic [BIT_W-1:0] bit_idx;

    assign done = active && (phase == PH_LAST) && (bit_idx == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            phase     <= '0;
            bit_idx   <= '0;
            tlu_clock <= 1'b0;
            data      <= '0;
        end else if (start) begin
            active    <= 1'b1;
            phase     <= '0;
            bit_idx   <= '0;
            tlu_clock <= 1'b1;
            data      <= '0;
        end else if (active) begin
            // Sample on the last high cycle so the TLU has the whole high phase to settle.
            if (phase == PH_SAMPLE)
                data <= (data >> 1) | (DATA_WIDTH'(data_in) << (DATA_WIDTH - 1));
            if (phase == PH_LAST) begin
                phase <= '0;
                if (bit_idx == BIT_LAST) begin
                    active    <= 1'b0;
                    tlu_clock <= 1'b0;
                end else begin
                    bit_idx   <= bit_idx + 1'b1;
                    tlu_clock <= 1'b1;
                end
            end else begin
                phase     <= phase + 1'b1;
                tlu_clock <= (phase < PH_SAMPLE);
            end
        end
    end

endmodule

// File: rtl/tlu_handshake_controller.sv
// TLU trigger controller: accepts triggers, starts the CMD FSM, handles the
// simple/data handshakes with the TLU and hands trigger numbers to readout.
module tlu_handshake_controller #(
    parameter int DATA_WIDTH    = 15,
    parameter int TIMEOUT_WIDTH = 8,
    parameter int CCK_HALF      = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic [1:0]               TLU_MODE,
    input  logic [TIMEOUT_WIDTH-1:0] TRIGGER_LOW_TIMEOUT,
    input  logic                     TLU_TRIGGER,
    output logic                     TLU_BUSY,
    output logic                     TLU_CLOCK,
    input  logic                     CMD_READY,
    output logic                     CMD_START,
    input  logic                     FIFO_NEAR_FULL,
    output logic [DATA_WIDTH-1:0]    TRIGGER_NUMBER,
    output logic                     TRIGGER_VALID,
    input  logic                     TRIGGER_ACK,
    output logic                     TIMEOUT_ERROR,
    output logic [CNT_WIDTH-1:0]     TRIGGER_COUNT,
    output logic [CNT_WIDTH-1:0]     SKIPPED_COUNT,
    output logic [CNT_WIDTH-1:0]     ERROR_COUNT
);

    import tlu_handshake_pkg::*;

    state_t                   state, state_nxt;
    logic [1:0]               mode_q, mode_nxt;
    logic                     trig_q;
    logic [TIMEOUT_WIDTH-1:0] timer;

    logic                     trig_edge;
    logic                     ready;
    logic                     skip;
    logic                     timeout_hit;
    logic                     ack_take;
    logic                     shift_start;
    logic                     shift_done;
    logic                     busy_nxt;
    logic [DATA_WIDTH-1:0]    shift_data;
    logic [DATA_WIDTH-1:0]    count_num;

    tlu_data_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CCK_HALF   (CCK_HALF)
    ) u_shifter (
        .clk       (CLK),
        .reset     (RESET),
        .start     (shift_start),
        .data_in   (TLU_TRIGGER),
        .tlu_clock (TLU_CLOCK),
        .done      (shift_done),
        .data      (shift_data)
    );

    assign trig_edge = TLU_TRIGGER & ~trig_q;
    assign ready     = ENABLE & CMD_READY & ~FIFO_NEAR_FULL;
    assign count_num = DATA_WIDTH'(TRIGGER_COUNT);

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        skip        = 1'b0;
        timeout_hit = 1'b0;
        ack_take    = 1'b0;
        shift_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_edge) begin
                    if (ready) begin
                        state_nxt = ST_SEND_CMD;
                        mode_nxt  = norm_mode(TLU_MODE);
                    end else begin
                        skip = 1'b1;
                    end
                end
            end
            ST_SEND_CMD:
                state_nxt = (mode_q == MODE_NONE) ? ST_PRESENT : ST_WAIT_TRIG_LOW;
            ST_WAIT_TRIG_LOW: begin
                if (!TLU_TRIGGER) begin
                    if (mode_q == MODE_DATA) begin
                        state_nxt   = ST_SHIFT;
                        shift_start = 1'b1;
                    end else begin
                        state_nxt = ST_PRESENT;
                    end
                end else if ((TRIGGER_LOW_TIMEOUT != '0) &&
                             (timer == TRIGGER_LOW_TIMEOUT - 1'b1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_SHIFT:
                if (shift_done) state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                if (TRIGGER_ACK) begin
                    ack_take  = 1'b1;
                    state_nxt = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD:
                if (CMD_READY) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
        // Without a handshake the TLU is never held off, so every busy-time edge is lost.
        if ((state != ST_IDLE) && (mode_q == MODE_NONE) && trig_edge)
            skip = 1'b1;
    end

    always_comb begin
        if (state_nxt == ST_IDLE)
            busy_nxt = is_handshake(TLU_MODE) & ~ready;
        else
            busy_nxt = is_handshake(mode_nxt);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_NONE;
            trig_q         <= 1'b0;
            timer          <= '0;
            TLU_BUSY       <= 1'b0;
            CMD_START      <= 1'b0;
            TRIGGER_VALID  <= 1'b0;
            TRIGGER_NUMBER <= '0;
            TIMEOUT_ERROR  <= 1'b0;
            TRIGGER_COUNT  <= '0;
            SKIPPED_COUNT  <= '0;
            ERROR_COUNT    <= '0;
        end else begin
            state         <= state_nxt;
            mode_q        <= mode_nxt;
            trig_q        <= TLU_TRIGGER;
            TLU_BUSY      <= busy_nxt;
            CMD_START     <= (state_nxt == ST_SEND_CMD);
            TRIGGER_VALID <= (state_nxt == ST_PRESENT);
            TIMEOUT_ERROR <= timeout_hit;

            if (state != ST_WAIT_TRIG_LOW)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;

            // Number is captured once on entry so it stays stable while readout stalls.
            if ((state_nxt == ST_PRESENT) && (state != ST_PRESENT))
                TRIGGER_NUMBER <= (mode_q == MODE_DATA) ? shift_data : count_num;

            if (ack_take && (TRIGGER_COUNT != '1))
                TRIGGER_COUNT <= TRIGGER_COUNT + 1'b1;
            if (skip && (SKIPPED_COUNT != '1))
                SKIPPED_COUNT <= SKIPPED_COUNT + 1'b1;
            if (timeout_hit && (ERROR_COUNT != '1))
                ERROR_COUNT <= ERROR_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlu_handshake_controller.sv
// Directed bench for tlu_handshake_controller: per-cycle vector tables plus
// hand-written sequences for data shifting, timeout, reset and mode switching.
module tb_tlu_handshake_controller;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [1:0]  TLU_MODE;
    logic [7:0]  TRIGGER_LOW_TIMEOUT;
    logic        TLU_TRIGGER;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic        CMD_READY;
    logic        CMD_START;
    logic        FIFO_NEAR_FULL;
    logic [14:0] TRIGGER_NUMBER;
    logic        TRIGGER_VALID;
    logic        TRIGGER_ACK;
    logic        TIMEOUT_ERROR;
    logic [15:0] TRIGGER_COUNT;
    logic [15:0] SKIPPED_COUNT;
    logic [15:0] ERROR_COUNT;

    int total = 0;
    int bad   = 0;

    tlu_handshake_controller #(
        .DATA_WIDTH    (15),
        .TIMEOUT_WIDTH (8),
        .CCK_HALF      (2),
        .CNT_WIDTH     (16)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .ENABLE              (ENABLE),
        .TLU_MODE            (TLU_MODE),
        .TRIGGER_LOW_TIMEOUT (TRIGGER_LOW_TIMEOUT),
        .TLU_TRIGGER         (TLU_TRIGGER),
        .TLU_BUSY            (TLU_BUSY),
        .TLU_CLOCK           (TLU_CLOCK),
        .CMD_READY           (CMD_READY),
        .CMD_START           (CMD_START),
        .FIFO_NEAR_FULL      (FIFO_NEAR_FULL),
        .TRIGGER_NUMBER      (TRIGGER_NUMBER),
        .TRIGGER_VALID       (TRIGGER_VALID),
        .TRIGGER_ACK         (TRIGGER_ACK),
        .TIMEOUT_ERROR       (TIMEOUT_ERROR),
        .TRIGGER_COUNT       (TRIGGER_COUNT),
        .SKIPPED_COUNT       (SKIPPED_COUNT),
        .ERROR_COUNT         (ERROR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mode;
        logic       fnf;
        logic       trig;
        logic       ack;
        logic       x_start;
        logic       x_busy;
        logic       x_valid;
        int         x_num;
        int         x_tcnt;
        int         x_scnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] mode, logic fnf, logic trig, logic ack,
                                logic xs, logic xb, logic xv, int xn, int xt, int xsk);
        vec_t v;
        v.mode = mode; v.fnf = fnf; v.trig = trig; v.ack = ack;
        v.x_start = xs; v.x_busy = xb; v.x_valid = xv;
        v.x_num = xn; v.x_tcnt = xt; v.x_scnt = xsk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; TLU_TRIGGER = 1'b0; TRIGGER_ACK = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            TLU_MODE       = vecs[i].mode;
            FIFO_NEAR_FULL = vecs[i].fnf;
            TLU_TRIGGER    = vecs[i].trig;
            TRIGGER_ACK    = vecs[i].ack;
            tick();
            chk($sformatf("%s[%0d].start", tag, i), 32'(CMD_START), 32'(vecs[i].x_start));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(TLU_BUSY), 32'(vecs[i].x_busy));
            chk($sformatf("%s[%0d].valid", tag, i), 32'(TRIGGER_VALID), 32'(vecs[i].x_valid));
            if (vecs[i].x_valid)
                chk($sformatf("%s[%0d].num", tag, i), 32'(TRIGGER_NUMBER), 32'(vecs[i].x_num));
            chk($sformatf("%s[%0d].tcnt", tag, i), 32'(TRIGGER_COUNT), 32'(vecs[i].x_tcnt));
            chk($sformatf("%s[%0d].scnt", tag, i), 32'(SKIPPED_COUNT), 32'(vecs[i].x_scnt));
        end
        TRIGGER_ACK = 1'b0;
    endtask

    // Acts as the TLU for one 60-cycle SHIFT: drives bit k for the whole of pulse k
    // and checks the clock waveform, busy and that nothing is presented early.
    task automatic shift_in(input string tag, input logic [14:0] val, input int switch_at);
        int clk_bad = 0, valid_bad = 0, busy_bad = 0, pulses = 0;
        logic prev = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (TLU_CLOCK !== ((cyc % 4) < 2)) clk_bad++;
            if (TLU_CLOCK && !prev) pulses++;
            if (TRIGGER_VALID !== 1'b0) valid_bad++;
            if (TLU_BUSY !== 1'b1) busy_bad++;
            prev = TLU_CLOCK;
            if (cyc == switch_at) TLU_MODE = 2'b00;
            TLU_TRIGGER = val[cyc / 4];
            tick();
        end
        TLU_TRIGGER = 1'b0;
        chk({tag, ".clk_pattern_errs"}, 32'(clk_bad), 32'd0);
        chk({tag, ".pulses"}, 32'(pulses), 32'd15);
        chk({tag, ".early_valid"}, 32'(valid_bad), 32'd0);
        chk({tag, ".busy_drop"}, 32'(busy_bad), 32'd0);
        chk({tag, ".clk_after"}, 32'(TLU_CLOCK), 32'd0);
        chk({tag, ".valid"}, 32'(TRIGGER_VALID), 32'd1);
        chk({tag, ".num"}, 32'(TRIGGER_NUMBER), 32'(val));
    endtask

    // Edge, SEND_CMD, WAIT_TRIG_LOW with trigger dropped -> first SHIFT cycle.
    task automatic start_data_txn(input string tag);
        TLU_MODE = 2'b10; TLU_TRIGGER = 1'b1;
        tick();
        chk({tag, ".start"}, 32'(CMD_START), 32'd1);
        chk({tag, ".busy"}, 32'(TLU_BUSY), 32'd1);
        tick();
        TLU_TRIGGER = 1'b0;
        tick();
    endtask

    initial begin
        int hit_at;
        logic seen_valid;
        RESET = 1'b1; ENABLE = 1'b1; TLU_MODE = 2'b00; TRIGGER_LOW_TIMEOUT = 8'd0;
        TLU_TRIGGER = 1'b0; CMD_READY = 1'b1; FIFO_NEAR_FULL = 1'b0; TRIGGER_ACK = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        chk("rst.busy", 32'(TLU_BUSY), 32'd0);
        chk("rst.clock", 32'(TLU_CLOCK), 32'd0);
        chk("rst.start", 32'(CMD_START), 32'd0);
        chk("rst.valid", 32'(TRIGGER_VALID), 32'd0);
        chk("rst.counts", 32'({TRIGGER_COUNT, SKIPPED_COUNT | ERROR_COUNT}), 32'd0);

        // Mode 00: numbers 0,1,2 from the trigger counter, edge in PRESENT is skipped.
        vecs.delete();
        vecs.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 2, 2, 1));
        vecs.push_back(mk(2'b00, 0, 1, 1, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        run_table("m00");

        // Mode 01 with readout back-pressure: every edge is skipped, TLU held busy.
        do_reset();
        vecs.delete();
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b01, 1, 1, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(2'b01, 1, 1, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(2'b01, 1, 1, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0, 0, 0, 3));
        run_table("m01_full");
        FIFO_NEAR_FULL = 1'b0;

        // Mode 10: shift in 0x1234, hold VALID through a stalled ack.
        do_reset();
        start_data_txn("m10");
        shift_in("m10", 15'h1234, -1);
        tick(); tick();
        chk("m10.hold_valid", 32'(TRIGGER_VALID), 32'd1);
        chk("m10.hold_num", 32'(TRIGGER_NUMBER), 32'h1234);
        TRIGGER_ACK = 1'b1;
        tick();
        TRIGGER_ACK = 1'b0;
        chk("m10.ack_valid", 32'(TRIGGER_VALID), 32'd0);
        chk("m10.ack_tcnt", 32'(TRIGGER_COUNT), 32'd1);
        chk("m10.waitcmd_busy", 32'(TLU_BUSY), 32'd1);
        tick();
        chk("m10.idle_busy", 32'(TLU_BUSY), 32'd0);

        // Reset 20 cycles into a SHIFT aborts everything.
        start_data_txn("rst_shift");
        for (int i = 0; i < 20; i++) tick();
        chk("rst_shift.clk_before", 32'(TLU_CLOCK), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_shift.clock", 32'(TLU_CLOCK), 32'd0);
        chk("rst_shift.busy", 32'(TLU_BUSY), 32'd0);
        chk("rst_shift.valid", 32'(TRIGGER_VALID), 32'd0);
        chk("rst_shift.tcnt", 32'(TRIGGER_COUNT), 32'd0);
        TLU_MODE = 2'b01; TLU_TRIGGER = 1'b1;
        tick();
        chk("rst_after.start", 32'(CMD_START), 32'd1);
        tick();
        TLU_TRIGGER = 1'b0;
        tick();
        chk("rst_after.valid", 32'(TRIGGER_VALID), 32'd1);
        chk("rst_after.num", 32'(TRIGGER_NUMBER), 32'd0);
        TRIGGER_ACK = 1'b1;
        tick();
        TRIGGER_ACK = 1'b0;
        chk("rst_after.tcnt", 32'(TRIGGER_COUNT), 32'd1);
        tick();

        // Mode 01 timeout: trigger held high for 10 WAIT_TRIG_LOW cycles.
        do_reset();
        TLU_MODE = 2'b01; TRIGGER_LOW_TIMEOUT = 8'd10; TLU_TRIGGER = 1'b1;
        hit_at = 0; seen_valid = 1'b0;
        for (int n = 1; n <= 40 && hit_at == 0; n++) begin
            tick();
            if (TRIGGER_VALID) seen_valid = 1'b1;
            if (TIMEOUT_ERROR) hit_at = n;
        end
        chk("tmo.cycle", 32'(hit_at), 32'd12);
        chk("tmo.errcnt", 32'(ERROR_COUNT), 32'd1);
        chk("tmo.no_valid", 32'(seen_valid), 32'd0);
        chk("tmo.idle_busy", 32'(TLU_BUSY), 32'd0);
        tick();
        chk("tmo.pulse_once", 32'(TIMEOUT_ERROR), 32'd0);
        FIFO_NEAR_FULL = 1'b1;
        tick();
        chk("tmo.busy_tracks", 32'(TLU_BUSY), 32'd1);
        chk("tmo.tcnt", 32'(TRIGGER_COUNT), 32'd0);
        FIFO_NEAR_FULL = 1'b0; TLU_TRIGGER = 1'b0; TRIGGER_LOW_TIMEOUT = 8'd0;

        // Mode switched 10 -> 00 mid-SHIFT: transaction stays mode 10, next one is mode 00.
        do_reset();
        start_data_txn("msw");
        shift_in("msw", 15'h2B6D, 8);
        TRIGGER_ACK = 1'b1;
        tick();
        TRIGGER_ACK = 1'b0;
        chk("msw.waitcmd_busy", 32'(TLU_BUSY), 32'd1);
        tick();
        chk("msw.idle_busy", 32'(TLU_BUSY), 32'd0);
        TLU_TRIGGER = 1'b1;
        tick();
        chk("msw.next_start", 32'(CMD_START), 32'd1);
        chk("msw.next_busy", 32'(TLU_BUSY), 32'd0);
        tick();
        chk("msw.next_valid", 32'(TRIGGER_VALID), 32'd1);
        chk("msw.next_num", 32'(TRIGGER_NUMBER), 32'd1);
        TRIGGER_ACK = 1'b1;
        tick();
        TRIGGER_ACK = 1'b0;
        chk("msw.next_tcnt", 32'(TRIGGER_COUNT), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlu_handshake_controller.md
Name: tlu_handshake_controller

Overview:
Parametrised second-generation TLU trigger controller.
- Accepts triggers from the TLU, issues a start pulse to the CMD FSM, and drives TLU busy/veto.
- In data-handshake mode, it generates the TLU clock itself and shifts in the TLU trigger number.
- Presents one trigger number per accepted trigger to readout with a valid/ack handshake.
- Keeps saturating trigger, skipped-trigger and timeout-error counters.
- Sits between the synchronised TLU inputs and the CMD/readout FSMs.

Parameters:
DATA_WIDTH, 15, trigger-number bits shifted in from the TLU and width of TRIGGER_NUMBER.
TIMEOUT_WIDTH, 8, width of the trigger-low timeout counter.
CCK_HALF, 2, TLU_CLOCK half-period in CLK cycles (>=1).
CNT_WIDTH, 16, width of the statistics counters.

Ports:
CLK  in  1  single clock.
RESET  in  1  synchronous, active-high.
ENABLE  in  1  trigger acceptance enable.
TLU_MODE  in  2  00 no handshake, 01 simple handshake, 10 data handshake, 11 treated as 00.
TRIGGER_LOW_TIMEOUT  in  TIMEOUT_WIDTH  cycles allowed for trigger to go low; 0 disables.
TLU_TRIGGER  in  1  TLU trigger/data line, already synchronised to CLK.
TLU_BUSY  out  1  busy/veto to TLU.
TLU_CLOCK  out  1  trigger-data clock to TLU.
CMD_READY  in  1  CMD FSM idle.
CMD_START  out  1  one-cycle start pulse.
FIFO_NEAR_FULL  in  1  readout back-pressure.
TRIGGER_NUMBER  out  DATA_WIDTH  trigger number presented to readout.
TRIGGER_VALID  out  1  number valid.
TRIGGER_ACK  in  1  readout consumed the number.
TIMEOUT_ERROR  out  1  one-cycle pulse on trigger-low timeout.
TRIGGER_COUNT  out  CNT_WIDTH  accepted triggers, saturating.
SKIPPED_COUNT  out  CNT_WIDTH  rejected trigger edges, saturating.
ERROR_COUNT  out  CNT_WIDTH  timeouts, saturating.

Behaviour:
- Reset: all outputs and counters are 0 and the state is IDLE. A reset mid-transaction aborts immediately: TLU_CLOCK and TLU_BUSY are 0 on the next cycle and no partial number is presented.
- Edge detect: edge = TLU_TRIGGER & ~TLU_TRIGGER_q (registered copy of the previous cycle).
- Accept condition in IDLE: edge & ENABLE & CMD_READY & ~FIFO_NEAR_FULL. On accept, TLU_MODE is latched; mode changes mid-transaction have no effect.
- Rejected edges (SKIPPED_COUNT +1):
  - An IDLE edge that fails the accept condition.
  - Any edge outside IDLE in latched mode 00.
  - Edges outside IDLE in modes 01/10 are ignored, because the TLU is held busy.
- All outputs are registered and decoded from the next state. Edge sampled at cycle n gives CMD_START=1 and TLU_BUSY=1 (modes 01/10) at n+1.
- TLU_BUSY in IDLE: modes 01/10 drive ~(ENABLE & CMD_READY & ~FIFO_NEAR_FULL). Mode 00 holds TLU_BUSY at 0 in every state.
- States:
  - IDLE -> SEND_CMD on accept.
  - SEND_CMD (1 cycle, CMD_START=1): mode 00 -> PRESENT; modes 01/10 -> WAIT_TRIG_LOW.
  - WAIT_TRIG_LOW: timer counts from 0 each cycle, saturating.
    - TLU_TRIGGER=0 -> PRESENT (mode 01) or SHIFT (mode 10).
    - Otherwise, if TRIGGER_LOW_TIMEOUT!=0 and timer==TRIGGER_LOW_TIMEOUT-1: TIMEOUT_ERROR pulse, ERROR_COUNT +1, -> IDLE. TRIGGER_COUNT is unchanged and no number is presented.
  - SHIFT: DATA_WIDTH pulses on TLU_CLOCK, each CCK_HALF cycles high then CCK_HALF low.
    - TLU_TRIGGER is sampled in the last high cycle of each pulse; the first sampled bit is bit 0 (LSB first).
    - Duration is exactly 2*CCK_HALF*DATA_WIDTH cycles, then -> PRESENT.
  - PRESENT: TRIGGER_VALID=1 with TRIGGER_NUMBER held stable until TRIGGER_ACK=1.
    - The ack cycle drops VALID on the next cycle, increments TRIGGER_COUNT, and -> WAIT_CMD.
    - TRIGGER_NUMBER source: modes 00/01 present TRIGGER_COUNT before increment, truncated or zero-extended to DATA_WIDTH; mode 10 presents the shifted value.
  - WAIT_CMD: -> IDLE when CMD_READY=1; minimum 1 cycle.
- ENABLE or FIFO_NEAR_FULL changing mid-transaction: the transaction completes; they take effect only in IDLE.
- TLU_BUSY stays 1 from SEND_CMD through WAIT_CMD in modes 01/10.
- Counters saturate at all-ones; no wrap-around.

Decomposition:
- Package tlu_handshake_pkg: mode constants (MODE_NONE=2'b00, MODE_SIMPLE=2'b01, MODE_DATA=2'b10) and the state encoding.
- Sub-module tlu_data_shifter (DATA_WIDTH, CCK_HALF) contains the TLU_CLOCK generator, bit counter and shift register, with a start/done handshake.

Test Plan:
- Mode 10, CCK_HALF=2, TLU serialises 0x1234 LSB first -> 15 TLU_CLOCK pulses over 60 cycles, TRIGGER_NUMBER=0x1234, VALID until ACK, TRIGGER_COUNT=1.
- Mode 01, timeout=10, trigger held high -> TIMEOUT_ERROR pulse once, ERROR_COUNT=1, no VALID, TLU_BUSY tracks the IDLE rule afterwards.
- Mode 01, FIFO_NEAR_FULL=1, three edges -> no CMD_START, SKIPPED_COUNT=3, TLU_BUSY=1 throughout.
- Mode 00, three triggers with prompt ACK -> TRIGGER_NUMBER 0,1,2, TLU_BUSY always 0; an edge during PRESENT -> SKIPPED_COUNT +1.
- RESET asserted in SHIFT at cycle 20 -> next cycle TLU_CLOCK=0, TLU_BUSY=0, VALID=0, counters 0; a new trigger then completes normally.
- TLU_MODE switched 10->00 during SHIFT -> transaction completes as mode 10; the next trigger runs as mode 00.
